// File: rtl/srt_link_if.sv
// Signal bundle for the srt_link_param serial link: TX request/word, serial pins,
// and the RX FIFO dry/ack handshake.
interface srt_link_if #(parameter int DATA_W = 8) ();
   logic              send;
   logic [DATA_W-1:0] d;
   logic              busy;
   logic              tx;
   logic              en;
   logic              rx;
   logic              dry;
   logic              ack;
   logic [DATA_W-1:0] q;
   logic              err;
   logic              ovf;

   modport slave  (input  send, d, en, rx, ack,
                   output busy, tx, dry, q, err, ovf);
   modport master (output send, d, en, rx, ack,
                   input  busy, tx, dry, q, err, ovf);
endinterface

// File: rtl/srt_link_param.sv
// Parametrised serial TX/RX link with an RX FIFO behind a dry/ack handshake.
// Optional even parity bit: define SRT_PARITY_EN.
//
// state   | meaning (shared by TX and RX FSMs)
// S_IDLE  | line idle / waiting for send or start edge
// S_START | start bit (0)
// S_DATA  | DATA_W data bits
// S_PAR   | even parity bit (SRT_PARITY_EN only)
// S_STOP  | stop bit (1)
module srt_link_param #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYC    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int LSB_FIRST  = 1
) (
   input logic       clk,
   input logic       rst,
   srt_link_if.slave bus
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int CW = $clog2(BIT_CYC);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
`ifdef SRT_PARITY_EN
   localparam logic [2:0] S_PAR   = 3'd4;
`endif

   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] SMP_AT   = CW'(BIT_CYC - 1 - BIT_CYC / 2);
   localparam logic [CW-1:0] DET_LOAD = CW'(BIT_CYC - 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

   function automatic logic [BW-1:0] bit_idx(input logic [BW-1:0] n);
      return (LSB_FIRST != 0) ? n : BIT_LAST - n;
   endfunction

   // ---------------- TX ----------------
   logic [2:0]        tx_st;
   logic [CW-1:0]     tx_cnt;
   logic [BW-1:0]     tx_bit;
   logic [DATA_W-1:0] tx_word;
   logic              tx_q, busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st   <= S_IDLE;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_word <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else if (tx_st == S_IDLE) begin
         if (bus.send) begin
            tx_word <= bus.d;
            tx_st   <= S_START;
            tx_cnt  <= CYC_LAST;
            tx_bit  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
         end
      end else if (tx_cnt != '0) begin
         tx_cnt <= tx_cnt - 1'b1;
      end else begin
         tx_cnt <= CYC_LAST;
         case (tx_st)
            S_START: begin
               tx_st <= S_DATA;
               tx_q  <= tx_word[bit_idx(BW'(0))];
            end
            S_DATA: begin
               if (tx_bit == BIT_LAST) begin
`ifdef SRT_PARITY_EN
                  tx_st <= S_PAR;
                  tx_q  <= ^tx_word;
`else
                  tx_st <= S_STOP;
                  tx_q  <= 1'b1;
`endif
               end else begin
                  tx_bit <= tx_bit + 1'b1;
                  tx_q   <= tx_word[bit_idx(tx_bit + 1'b1)];
               end
            end
`ifdef SRT_PARITY_EN
            S_PAR: begin
               tx_st <= S_STOP;
               tx_q  <= 1'b1;
            end
`endif
            default: begin
               tx_st  <= S_IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------- RX ----------------
   // Down-counter per bit; the detection cycle counts as the first cycle of the start bit.
   logic [2:0]        rx_st;
   logic [CW-1:0]     rx_cnt;
   logic [BW-1:0]     rx_bit;
   logic [DATA_W-1:0] rx_word;
   logic              err_q;
   logic              rx_smp, rx_end, push;

   assign rx_smp = (rx_cnt == SMP_AT);
   assign rx_end = (rx_cnt == '0);

`ifdef SRT_PARITY_EN
   logic rx_par_bad;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rx_par_bad <= 1'b0;
      else if (rx_st == S_PAR && rx_smp)
         rx_par_bad <= bus.rx ^ (^rx_word);
   end
   assign push = (rx_st == S_STOP) && rx_smp && bus.rx && !rx_par_bad;
`else
   assign push = (rx_st == S_STOP) && rx_smp && bus.rx;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_st   <= S_IDLE;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_word <= '0;
         err_q   <= 1'b0;
      end else if (rx_st == S_IDLE) begin
         if (bus.en && !bus.rx) begin
            rx_st  <= S_START;
            rx_cnt <= DET_LOAD;
            rx_bit <= '0;
         end
      end else begin
         rx_cnt <= rx_end ? CYC_LAST : rx_cnt - 1'b1;
         case (rx_st)
            S_START: begin
               if (rx_smp && bus.rx) rx_st <= S_IDLE;
               else if (rx_end)      rx_st <= S_DATA;
            end
            S_DATA: begin
               if (rx_smp) rx_word[bit_idx(rx_bit)] <= bus.rx;
               if (rx_end) begin
                  if (rx_bit == BIT_LAST)
`ifdef SRT_PARITY_EN
                     rx_st <= S_PAR;
`else
                     rx_st <= S_STOP;
`endif
                  else
                     rx_bit <= rx_bit + 1'b1;
               end
            end
`ifdef SRT_PARITY_EN
            S_PAR: if (rx_end) rx_st <= S_STOP;
`endif
            default: begin
               if (rx_smp) begin
                  rx_st <= S_IDLE;
                  if (!push) err_q <= 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- FIFO ----------------
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [AW:0]       cnt;
   logic              dry, pop, full, wr, ovf_q;

   assign dry  = (cnt != '0);
   assign full = (cnt == CNT_FULL);
   assign pop  = bus.ack && dry;
   assign wr   = push && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (wr)  wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         if (wr && !pop)      cnt <= cnt + 1'b1;
         else if (!wr && pop) cnt <= cnt - 1'b1;
         if (push && !wr) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= rx_word;
   end

   assign bus.busy = busy_q;
   assign bus.tx   = tx_q;
   assign bus.dry  = dry;
   assign bus.q    = dry ? mem[rp] : '0;
   assign bus.err  = err_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_srt_link_param.sv
// Directed bench for srt_link_param: loopback and injected frames, FIFO corner cases.
module tb_srt_link_param;
   localparam int DW = 8;
   localparam int BC = 4;
`ifdef SRT_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F     = (DW + 2 + P) * BC;
   localparam int PUSHC = 1 + (DW + 1 + P) * BC + BC / 2;
   localparam int DRYC  = PUSHC + 1;
   localparam int LIMIT = 4 * F;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic loopb = 1'b1;
   logic rx_drv = 1'b1;
   int   checks = 0;
   int   errors = 0;

   srt_link_if #(.DATA_W(DW)) bus ();
   assign bus.rx = loopb ? bus.tx : rx_drv;

   srt_link_param #(.DATA_W(DW), .BIT_CYC(BC), .FIFO_DEPTH(4), .LSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       par_flip;
      logic       stop;
      logic       exp_dry;
      logic       exp_err;
   } inj_t;
   typedef struct {
      logic [7:0] d;
      logic [7:0] q;
   } lv_t;

   inj_t inj_tab[3];
   lv_t  lv_tab[4];

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic send_word(input logic [7:0] w);
      int n = 0;
      while (bus.busy && n < LIMIT) begin
         tick(1);
         n++;
      end
      if (bus.busy) check("send_timeout", 32'(bus.busy), 0);
      bus.send = 1'b1;
      bus.d    = w;
      tick(1);
      bus.send = 1'b0;
   endtask

   task automatic wait_recv(input string name, input logic [7:0] w);
      int n = 0;
      while (!bus.dry && n < LIMIT) begin
         tick(1);
         n++;
      end
      check({name, "_dry"}, 32'(bus.dry), 1);
      check({name, "_q"}, 32'(bus.q), 32'(w));
      bus.ack = 1'b1;
      tick(1);
      bus.ack = 1'b0;
   endtask

   task automatic inject(input logic [7:0] data, input logic par_flip, input logic stop);
      loopb  = 1'b0;
      rx_drv = 1'b0;
      tick(BC);
      for (int i = 0; i < DW; i++) begin
         rx_drv = data[i];
         tick(BC);
      end
      if (P != 0) begin
         rx_drv = (^data) ^ par_flip;
         tick(BC);
      end
      rx_drv = stop;
      tick(BC);
      rx_drv = 1'b1;
      tick(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      inj_tab[0] = '{data: 8'h96, par_flip: 1'b0, stop: 1'b1, exp_dry: 1'b1, exp_err: 1'b0};
      inj_tab[1] = '{data: 8'h3C, par_flip: 1'b0, stop: 1'b0, exp_dry: 1'b0, exp_err: 1'b1};
      inj_tab[2] = '{data: 8'h5A, par_flip: 1'b0, stop: 1'b1, exp_dry: 1'b1, exp_err: 1'b1};
      lv_tab[0]  = '{d: 8'h00, q: 8'h00};
      lv_tab[1]  = '{d: 8'hFF, q: 8'hFF};
      lv_tab[2]  = '{d: 8'h81, q: 8'h81};
      lv_tab[3]  = '{d: 8'h5A, q: 8'h5A};

      bus.send = 1'b0;
      bus.d    = '0;
      bus.en   = 1'b1;
      bus.ack  = 1'b0;
      tick(2);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_tx",   32'(bus.tx),   1);
      check("rst_dry",  32'(bus.dry),  0);
      check("rst_q",    32'(bus.q),    0);
      check("rst_err",  32'(bus.err),  0);
      check("rst_ovf",  32'(bus.ovf),  0);
      rst = 1'b0;
      tick(1);

      // cycle-exact frame of 0xA5, back-to-back 0x3C right as busy drops
      bus.send = 1'b1;
      bus.d    = 8'hA5;
      for (int c = 1; c <= F + 2; c++) begin
         tick(1);
         if (c == 1) begin
            bus.send = 1'b0;
            check("t1_tx_c1", 32'(bus.tx), 0);
            check("t1_busy_c1", 32'(bus.busy), 1);
         end
         if (c == 4)  check("t1_tx_c4", 32'(bus.tx), 0);
         if (c == 5)  check("t1_tx_c5", 32'(bus.tx), 1);
         if (c == 10) bus.d = 8'hFF;
         if (c == F)  check("t1_busy_cF", 32'(bus.busy), 1);
         if (c == DRYC - 1) check("t1_dry_early", 32'(bus.dry), 0);
         if (c == DRYC) begin
            check("t1_dry", 32'(bus.dry), 1);
            check("t1_q", 32'(bus.q), 32'h A5);
            bus.ack = 1'b1;
         end
         if (c == DRYC + 1) begin
            bus.ack = 1'b0;
            check("t1_dry_after_ack", 32'(bus.dry), 0);
         end
         if (c == F + 1) begin
            check("t1_busy_drop", 32'(bus.busy), 0);
            bus.send = 1'b1;
            bus.d    = 8'h3C;
         end
         if (c == F + 2) begin
            bus.send = 1'b0;
            check("b2b_busy", 32'(bus.busy), 1);
            check("b2b_tx", 32'(bus.tx), 0);
         end
      end
      wait_recv("b2b", 8'h3C);
      check("t1_err", 32'(bus.err), 0);

      for (int i = 0; i < 4; i++) begin
         send_word(lv_tab[i].d);
         wait_recv($sformatf("loop%0d", i), lv_tab[i].q);
      end
      check("loop_err", 32'(bus.err), 0);

`ifdef SRT_PARITY_EN
      inject(8'h0F, 1'b1, 1'b1);
      check("par_err", 32'(bus.err), 1);
      check("par_dry", 32'(bus.dry), 0);
      loopb = 1'b1;
      send_word(8'h0F);
      wait_recv("par_good", 8'h0F);
      check("par_err_sticky", 32'(bus.err), 1);
      reset_dut();
`endif

      bus.en = 1'b0;
      inject(8'h11, 1'b0, 1'b1);
      check("en_off_dry", 32'(bus.dry), 0);
      bus.en = 1'b1;

      for (int i = 0; i < 3; i++) begin
         inject(inj_tab[i].data, inj_tab[i].par_flip, inj_tab[i].stop);
         check($sformatf("inj%0d_dry", i), 32'(bus.dry), 32'(inj_tab[i].exp_dry));
         check($sformatf("inj%0d_err", i), 32'(bus.err), 32'(inj_tab[i].exp_err));
         if (inj_tab[i].exp_dry) begin
            check($sformatf("inj%0d_q", i), 32'(bus.q), 32'(inj_tab[i].data));
            bus.ack = 1'b1;
            tick(1);
            bus.ack = 1'b0;
         end
      end

      rx_drv = 1'b0;
      tick(1);
      rx_drv = 1'b1;
      tick(3 * F);
      check("glitch_dry", 32'(bus.dry), 0);
      check("glitch_err", 32'(bus.err), 1);
      loopb = 1'b1;

      // overflow: five frames, no ack
      reset_dut();
      for (int i = 1; i <= 5; i++) send_word(8'(i));
      tick(F + 10);
      check("ovf_set", 32'(bus.ovf), 1);
      check("ovf_q_head", 32'(bus.q), 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovf_pop%0d", i), 32'(bus.q), 32'(i));
         bus.ack = 1'b1;
         tick(1);
         bus.ack = 1'b0;
      end
      check("ovf_empty", 32'(bus.dry), 0);

      // push and pop in the same cycle while full
      reset_dut();
      for (int i = 1; i <= 4; i++) send_word(8'(i));
      tick(F + 10);
      check("full_no_ovf", 32'(bus.ovf), 0);
      send_word(8'h05);
      tick(PUSHC - 1);
      bus.ack = 1'b1;
      tick(1);
      bus.ack = 1'b0;
      check("pp_ovf", 32'(bus.ovf), 0);
      for (int i = 2; i <= 5; i++) begin
         check($sformatf("pp_pop%0d", i), 32'(bus.q), 32'(i));
         bus.ack = 1'b1;
         tick(1);
         bus.ack = 1'b0;
      end
      check("pp_empty", 32'(bus.dry), 0);

      // reset in the middle of a TX and an RX frame
      send_word(8'h66);
      tick(F + 10);
      send_word(8'h77);
      tick(20);
      check("mid_pre_dry", 32'(bus.dry), 1);
      check("mid_pre_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      tick(1);
      check("mid_tx", 32'(bus.tx), 1);
      check("mid_busy", 32'(bus.busy), 0);
      check("mid_dry", 32'(bus.dry), 0);
      check("mid_err", 32'(bus.err), 0);
      rst = 1'b0;
      tick(2);
      send_word(8'h3C);
      wait_recv("post_rst", 8'h3C);
      check("post_rst_err", 32'(bus.err), 0);
      check("post_rst_ovf", 32'(bus.ovf), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
